lfsr_pattern_checker: RTL and testbench
=======================================

LFSR_PATTERN_CHECKER -- requirements
Module: lfsr_pattern_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, consecutive correct predictions needed to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 3, consecutive mismatches while locked that drop lock.
REQ-003 SHALL have parameter CNT_W, default 16, width of all statistics counters.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_tap  in  7  tap vector, same encoding as the pattern generator.
REQ-007 SHALL have port cfg_load  in  1  single-cycle pulse: latch cfg_tap and restart acquisition.
REQ-008 SHALL have port in_valid  in  1  received pattern word valid.
REQ-009 SHALL have port in_data  in  [0:7]  received pattern word, bit 0 leftmost.
REQ-010 SHALL have port in_ready  out  1  word accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port clr_cnt  in  1  synchronous clear of all counters.
REQ-012 SHALL have port locked  out  1  checker is synchronised to the stream.
REQ-013 SHALL have port err_pulse  out  1  one-cycle flag for a mismatch while locked.
REQ-014 SHALL have port err_cnt  out  CNT_W  mismatched words while locked.
REQ-015 SHALL have port word_cnt  out  CNT_W  words accepted while locked.

Function
REQ-016 SHALL compute the prediction P from Q as: P[0]=Q[7], and for k=1..7, P[k]=Q[k-1] XOR (cfg tap bit [7-k] AND Q[7]).
REQ-017 SHALL implement the FSM states HUNT, VERIFY and LOCKED, with reset state HUNT.
REQ-018 In HUNT, SHALL seed the predictor with any nonzero accepted word and go to VERIFY with match count 0.
REQ-019 In HUNT, SHALL discard an accepted word of 8'h00 (lock-up state) and remain in HUNT.
REQ-020 In VERIFY, on a match SHALL increment the match count and advance Q to P.
REQ-021 In VERIFY, when the LOCK_CNT-th consecutive match occurs, SHALL enter LOCKED.
REQ-022 In VERIFY, on a mismatch SHALL reseed Q from in_data, clear the match count and stay in VERIFY.
REQ-023 In LOCKED, SHALL advance Q to P on every accepted word, regardless of in_data.
REQ-024 In LOCKED, on a mismatch SHALL assert err_pulse, increment err_cnt and increment the miss count.
REQ-025 In LOCKED, on a match SHALL clear the miss count.
REQ-026 In LOCKED, when the LOSS_CNT-th consecutive miss occurs, SHALL enter HUNT.
REQ-027 In LOCKED, SHALL increment word_cnt on every accepted word.
REQ-028 SHALL register locked and err_pulse, so they update one cycle after the handshake.
REQ-029 SHALL drive in_ready high at all times except during reset and during the cycle cfg_load is high.
REQ-030 SHALL discard a word presented in the same cycle as cfg_load.
REQ-031 On cfg_load, SHALL go to HUNT next cycle, clear locked, and retain all counters.
REQ-032 SHALL saturate all counters at all-ones, with no wrap-around.
REQ-033 When clr_cnt coincides with a counted event, SHALL let clear win, leaving the counter at 0.

Reset
REQ-034 While rst_n is low, SHALL hold Q=0, taps=0, state HUNT, and all counts, locked, err_pulse and in_ready at 0.

Configuration
REQ-035 With HD_STATS_EN defined, SHALL add output bit_err_cnt [CNT_W], accumulating popcount(in_data XOR P) on each locked mismatch, saturating and cleared by clr_cnt.
REQ-036 Without HD_STATS_EN, bit_err_cnt SHALL be absent and no popcount logic SHALL exist.

Structure
REQ-037 SHALL place the state enum, the tap typedef (7 bits), the pattern typedef ([0:7]) and default parameter values in shared package lfsr_pkg.
REQ-038 SHALL implement the combinational next-pattern function as sub-module lfsr_next_fn, reusable by the generator.

Verification
REQ-039 Bench SHALL check: reset released, no traffic -> locked=0, all counts 0, in_ready=1.
REQ-040 Bench SHALL check: tap 7'h7F, stream 01,FF,80,40,20 -> locked=1 one cycle after 20 is accepted, err_cnt=0.
REQ-041 Bench SHALL check: locked, expected 10, send 11 -> one-cycle err_pulse, err_cnt=1, bit_err_cnt=1, locked stays 1, next expected 08.
REQ-042 Bench SHALL check: locked, three consecutive wrong words -> locked=0 after the third, FSM in HUNT, err_cnt=3.
REQ-043 Bench SHALL check: in HUNT send 00 -> no lock progress; cfg_load while locked -> in_ready=0 that cycle, locked=0 next cycle, counters retained.
REQ-044 Bench SHALL check: err_cnt forced near all-ones with an error -> saturates; clr_cnt with a simultaneous error -> err_cnt=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR pattern checker and generator.
// Optional build macro: HD_STATS_EN (bit-error statistics).
package lfsr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef logic [6:0] tap_t;
    typedef logic [0:7] pat_t;

    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 3;
    localparam int DEF_CNT_W    = 16;

`ifdef HD_STATS_EN
    function automatic logic [3:0] popcnt8(input pat_t v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/lfsr_next_fn.sv
// Combinational next-pattern function, shared by checker and generator.
// Bit 0 is the leftmost bit; bit 7 is the feedback bit.
module lfsr_next_fn
    import lfsr_pkg::*;
(
    input  logic [6:0] i_tap,
    input  logic [0:7] i_q,
    output logic [0:7] o_p
);

    assign o_p[0] = i_q[7];

    for (genvar k = 1; k < 8; k++) begin : g_bit
        assign o_p[k] = i_q[k-1] ^ (i_tap[7-k] & i_q[7]);
    end

endmodule

// File: rtl/lfsr_pattern_checker.sv
// Receive-side LFSR pattern checker: hunt, verify, lock and error stats.
// Optional build macro: HD_STATS_EN adds the bit_err_cnt output.
module lfsr_pattern_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       cfg_tap,
    input  logic             cfg_load,
    input  logic             in_valid,
    input  logic [0:7]       in_data,
    output logic             in_ready,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
`ifdef HD_STATS_EN
    output logic [CNT_W-1:0] bit_err_cnt,
`endif
    output logic [CNT_W-1:0] word_cnt
);

    localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

    state_e          r_state;
    state_e          w_state_nxt;
    tap_t            r_tap;
    pat_t            r_q;
    pat_t            w_q_nxt;
    pat_t            w_p;
    logic [MW-1:0]   r_match;
    logic [MW-1:0]   w_match_nxt;
    logic [LW-1:0]   r_miss;
    logic [LW-1:0]   w_miss_nxt;
    logic            r_locked;
    logic            r_err_pulse;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_word_cnt;
    logic            w_acc;
    logic            w_hit;
    logic            w_lword;
    logic            w_lerr;

    lfsr_next_fn u_next (
        .i_tap (r_tap),
        .i_q   (r_q),
        .o_p   (w_p)
    );

    // A word offered alongside cfg_load is never accepted.
    assign in_ready = rst_n & ~cfg_load;
    assign w_acc    = in_valid & in_ready;
    assign w_hit    = (in_data == w_p);
    assign w_lword  = w_acc & (r_state == LOCKED);
    assign w_lerr   = w_lword & ~w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_q     <= '0;
            r_match <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_match <= w_match_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        if (cfg_load) begin
            w_state_nxt = HUNT;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
        end else if (w_acc) begin
            unique case (r_state)
                HUNT: begin
                    // All-zero is the LFSR lock-up state; never seed on it.
                    if (in_data != '0) begin
                        w_q_nxt     = in_data;
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_hit) begin
                        w_q_nxt = w_p;
                        if (r_match == MW'(LOCK_CNT - 1)) begin
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_match_nxt = r_match + MW'(1);
                        end
                    end else begin
                        w_q_nxt     = in_data;
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_q_nxt = w_p;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else if (r_miss == LW'(LOSS_CNT - 1)) begin
                        w_miss_nxt  = '0;
                        w_state_nxt = HUNT;
                    end else begin
                        w_miss_nxt = r_miss + LW'(1);
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_tap <= cfg_tap;
            end
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_lerr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            if (clr_cnt) begin
                r_err_cnt <= '0;
            end else if (w_lerr && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (clr_cnt) begin
                r_word_cnt <= '0;
            end else if (w_lword && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HD_STATS_EN
    logic [CNT_W-1:0] r_bit_err;
    logic [CNT_W:0]   w_bsum;

    assign w_bsum = {1'b0, r_bit_err}
                  + (CNT_W+1)'(popcnt8(in_data ^ w_p));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_err <= '0;
        end else if (clr_cnt) begin
            r_bit_err <= '0;
        end else if (w_lerr) begin
            r_bit_err <= w_bsum[CNT_W] ? '1 : w_bsum[CNT_W-1:0];
        end
    end

    assign bit_err_cnt = r_bit_err;
`endif

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_lfsr_pattern_checker.sv
// Directed self-checking bench for lfsr_pattern_checker.
// Bit-error checks are compiled in only with HD_STATS_EN.
module tb_lfsr_pattern_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    cfg_tap = '0;
    logic          cfg_load = 1'b0;
    logic          in_valid = 1'b0;
    logic [0:7]    in_data = '0;
    logic          clr_cnt = 1'b0;
    logic          in_ready;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] word_cnt;
`ifdef HD_STATS_EN
    logic [CW-1:0] bit_err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_i  = 0;

    // Tap 7'h7F sequence, period 9.
    logic [7:0] tbl [9] = '{8'h01, 8'hFF, 8'h80, 8'h40, 8'h20,
                            8'h10, 8'h08, 8'h04, 8'h02};

    lfsr_pattern_checker #(
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_tap     (cfg_tap),
        .cfg_load    (cfg_load),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clr_cnt     (clr_cnt),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
`ifdef HD_STATS_EN
        .bit_err_cnt (bit_err_cnt),
`endif
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_locked: got %b expected 0", locked);
        end
        rst_n = 1'b1;
        idle();
        idle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL idle_flags: got %b%b expected 00",
                     locked, err_pulse);
        end
        checks++;
        if (err_cnt !== 4'd0 || word_cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_cnts: got %0d/%0d expected 0/0",
                     err_cnt, word_cnt);
        end
`ifdef HD_STATS_EN
        checks++;
        if (bit_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_bits: got %0d expected 0", bit_err_cnt);
        end
`endif
    endtask

    task automatic test_lock();
        cfg_tap  = 7'h7F;
        cfg_load = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        send(8'h01);
        send(8'hFF);
        send(8'h80);
        send(8'h40);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL early_lock: got %b expected 0", locked);
        end
        send(8'h20);
        exp_i = 5;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_at_20: got %b expected 1", locked);
        end
        checks++;
        if (err_cnt !== 4'd0 || word_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lock_cnts: got %0d/%0d expected 0/0",
                     err_cnt, word_cnt);
        end
    endtask

    task automatic test_single_err();
        send(8'h11);
        checks++;
        if (err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL err_flags: got p%b l%b expected p1 l1",
                     err_pulse, locked);
        end
        checks++;
        if (err_cnt !== 4'd1 || word_cnt !== 4'd1) begin
            errors++;
            $display("FAIL err_cnts: got %0d/%0d expected 1/1",
                     err_cnt, word_cnt);
        end
`ifdef HD_STATS_EN
        checks++;
        if (bit_err_cnt !== 4'd1) begin
            errors++;
            $display("FAIL err_bits: got %0d expected 1", bit_err_cnt);
        end
`endif
        idle();
        checks++;
        if (err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_len: got %b expected 0", err_pulse);
        end
        send(8'h08);
        checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 4'd1 ||
            word_cnt !== 4'd2) begin
            errors++;
            $display("FAIL next_08: got p%b e%0d w%0d expected p0 e1 w2",
                     err_pulse, err_cnt, word_cnt);
        end
        exp_i = 7;
    endtask

    task automatic test_loss();
        clr_cnt = 1'b1;
        idle();
        clr_cnt = 1'b0;
        chk("clr_err", 32'(err_cnt), 32'd0);
        send(8'hFF);
        send(8'hFF);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL two_miss: got %b expected 1", locked);
        end
        send(8'hFF);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL three_miss: got %b expected 0", locked);
        end
        chk("loss_err", 32'(err_cnt), 32'd3);
        chk("loss_word", 32'(word_cnt), 32'd3);
`ifdef HD_STATS_EN
        chk("loss_bits", 32'(bit_err_cnt), 32'd15);
`endif
    endtask

    task automatic test_hunt_zero();
        for (int i = 0; i < 6; i++) begin
            send(8'h00);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL zero_lock: got %b expected 0", locked);
        end
        chk("zero_err", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
        end
        chk("relock_early", 32'(locked), 32'd0);
        send(tbl[4]);
        chk("relock", 32'(locked), 32'd1);
        exp_i = 5;
    endtask

    task automatic test_cfg_load();
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = tbl[exp_i];
        #1;
        chk("cl_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        chk("cl_locked", 32'(locked), 32'd0);
        chk("cl_word", 32'(word_cnt), 32'd3);
        chk("cl_err", 32'(err_cnt), 32'd3);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            send(tbl[i]);
        end
        exp_i = 5;
        chk("sat_lock", 32'(locked), 32'd1);
        for (int i = 0; i < 13; i++) begin
            send(tbl[exp_i] ^ 8'h01);
            exp_i = (exp_i + 1) % 9;
            send(tbl[exp_i]);
            exp_i = (exp_i + 1) % 9;
        end
        chk("sat_err", 32'(err_cnt), 32'd15);
        chk("sat_word", 32'(word_cnt), 32'd15);
        chk("sat_lock2", 32'(locked), 32'd1);
        clr_cnt = 1'b1;
        send(tbl[exp_i] ^ 8'h01);
        clr_cnt = 1'b0;
        exp_i = (exp_i + 1) % 9;
        chk("clr_win_err", 32'(err_cnt), 32'd0);
        chk("clr_win_word", 32'(word_cnt), 32'd0);
        chk("clr_win_pulse", 32'(err_pulse), 32'd1);
`ifdef HD_STATS_EN
        chk("clr_win_bits", 32'(bit_err_cnt), 32'd0);
`endif
        send(tbl[exp_i]);
        exp_i = (exp_i + 1) % 9;
        chk("post_word", 32'(word_cnt), 32'd1);
        send(tbl[exp_i] ^ 8'h01);
        exp_i = (exp_i + 1) % 9;
        chk("post_err", 32'(err_cnt), 32'd1);
        chk("post_lock", 32'(locked), 32'd1);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_loss();
        test_hunt_zero();
        test_cfg_load();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
